rx_crc5_engine: RTL

//  Receive-side CRC-5 engine for the HDR-DDR path. Consumes each deserialized byte from RX
//  (data out + byte strobe, gated by RX crc_en), folds it bit-serially into a running CRC-5,
//  and returns the 5-bit value plus valid to RX for comparison with the received CRC field.

---
 rtl/gp_hdr_ddr_pkg.sv | 22 ++
 rtl/rx_crc5_engine_if.sv | 40 ++++
 rtl/rx_crc5_engine.sv | 137 +++++++++++++
 3 files changed

// File: rtl/gp_hdr_ddr_pkg.sv
// Shared HDR-DDR definitions: byte width, CRC-5 polynomial/seed, FSM states
// and the single-bit CRC-5 step function that the TX CRC reuses.
package gp_hdr_ddr_pkg;

    localparam int         DDR_BYTE_W = 8;
    localparam int         CRC5_W     = 5;
    localparam logic [4:0] CRC5_POLY  = 5'h05;  // x^5+x^2+1, x^5 term implicit
    localparam logic [4:0] CRC5_SEED  = 5'h1F;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } crc_state_t;

    // One CRC-5 step for one serial bit (MSB-first ordering is the caller's job).
    function automatic logic [4:0] crc5_step(input logic [4:0] crc, input logic din);
        logic fb;
        fb = crc[4] ^ din;
        return {crc[3:0], 1'b0} ^ (fb ? CRC5_POLY : 5'h00);
    endfunction

endpackage

// File: rtl/rx_crc5_engine_if.sv
// RX <-> CRC engine bus: seed pulse, byte strobe/data in, CRC result/status out.
interface rx_crc5_engine_if #(
    parameter int DATA_W = 8,
    parameter int CRC_W  = 5
) ();

    logic              i_ddrccc_crc_init;
    logic              i_rx_crc_en;
    logic              i_rx_byte_valid;
    logic [DATA_W-1:0] i_rx_byte;
    logic [CRC_W-1:0]  o_crc_value;
    logic              o_crc_valid;
    logic              o_crc_busy;
    logic              o_crc_overrun;

    // Driver side (RX / DDR CCC controller).
    modport master (
        output i_ddrccc_crc_init,
        output i_rx_crc_en,
        output i_rx_byte_valid,
        output i_rx_byte,
        input  o_crc_value,
        input  o_crc_valid,
        input  o_crc_busy,
        input  o_crc_overrun
    );

    // CRC engine side.
    modport slave (
        input  i_ddrccc_crc_init,
        input  i_rx_crc_en,
        input  i_rx_byte_valid,
        input  i_rx_byte,
        output o_crc_value,
        output o_crc_valid,
        output o_crc_busy,
        output o_crc_overrun
    );

endinterface

// File: rtl/rx_crc5_engine.sv
// Receive-side CRC-5 engine: folds each accepted RX byte MSB first, one bit per
// clock, into a running CRC and publishes the result when the byte completes.
module rx_crc5_engine
    import gp_hdr_ddr_pkg::*;
#(
    parameter int         DATA_W = DDR_BYTE_W,
    parameter int         CRC_W  = CRC5_W,
    parameter logic [4:0] POLY   = CRC5_POLY,
    parameter logic [4:0] SEED   = CRC5_SEED
) (
    input  logic                 i_sys_clk,
    input  logic                 i_sys_rst,
    rx_crc5_engine_if.slave      bus
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CRC_W-1:0] POLY_W   = CRC_W'(POLY);
    localparam logic [CRC_W-1:0] SEED_W   = CRC_W'(SEED);

    crc_state_t        state_reg, state_next;
    logic [DATA_W-1:0] shift_reg, shift_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [CRC_W-1:0]  crc_reg, crc_next;
    logic [CRC_W-1:0]  crc_value_reg, crc_value_next;
    logic              valid_reg, valid_next;
    logic              busy_reg, busy_next;
    logic              overrun_reg, overrun_next;

    logic              accept;
    logic [CRC_W-1:0]  crc_step;

    // Width-generic single-bit fold using the module's polynomial.
    function automatic logic [CRC_W-1:0] fold_bit(input logic [CRC_W-1:0] crc, input logic din);
        logic fb;
        fb = crc[CRC_W-1] ^ din;
        return {crc[CRC_W-2:0], 1'b0} ^ (fb ? POLY_W : '0);
    endfunction

    assign accept   = bus.i_rx_crc_en & bus.i_rx_byte_valid;
    assign crc_step = fold_bit(crc_reg, shift_reg[DATA_W-1]);

    // Next-state and next-output logic; init overrides everything, and a byte
    // strobed in the same cycle as init is accepted and folded from the seed.
    always_comb begin
        state_next     = state_reg;
        shift_next     = shift_reg;
        cnt_next       = cnt_reg;
        crc_next       = crc_reg;
        crc_value_next = crc_value_reg;
        valid_next     = valid_reg;
        busy_next      = busy_reg;
        overrun_next   = 1'b0;

        if (bus.i_ddrccc_crc_init) begin
            crc_next       = SEED_W;
            crc_value_next = SEED_W;
            if (accept) begin
                state_next = SHIFT;
                shift_next = bus.i_rx_byte;
                cnt_next   = CNT_LAST;
                valid_next = 1'b0;
                busy_next  = 1'b1;
            end else begin
                state_next = IDLE;
                cnt_next   = '0;
                valid_next = 1'b1;
                busy_next  = 1'b0;
            end
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        state_next = SHIFT;
                        shift_next = bus.i_rx_byte;
                        cnt_next   = CNT_LAST;
                        valid_next = 1'b0;
                        busy_next  = 1'b1;
                    end
                end
                SHIFT: begin
                    crc_next   = crc_step;
                    shift_next = {shift_reg[DATA_W-2:0], 1'b0};
                    // A strobe while folding cannot be queued: drop it and flag it.
                    overrun_next = accept;
                    if (cnt_reg == '0) begin
                        state_next     = IDLE;
                        crc_value_next = crc_step;
                        valid_next     = 1'b1;
                        busy_next      = 1'b0;
                    end else begin
                        cnt_next = cnt_reg - 1'b1;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // FSM, bit counter, shift register and working CRC.
    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            state_reg <= IDLE;
            shift_reg <= '0;
            cnt_reg   <= '0;
            crc_reg   <= SEED_W;
        end else begin
            state_reg <= state_next;
            shift_reg <= shift_next;
            cnt_reg   <= cnt_next;
            crc_reg   <= crc_next;
        end
    end

    // Registered outputs; the published CRC only moves on completion, init or reset.
    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            crc_value_reg <= SEED_W;
            valid_reg     <= 1'b1;
            busy_reg      <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            crc_value_reg <= crc_value_next;
            valid_reg     <= valid_next;
            busy_reg      <= busy_next;
            overrun_reg   <= overrun_next;
        end
    end

    assign bus.o_crc_value   = crc_value_reg;
    assign bus.o_crc_valid   = valid_reg;
    assign bus.o_crc_busy    = busy_reg;
    assign bus.o_crc_overrun = overrun_reg;

endmodule
